conv3_sequencer: RTL and testbench

Time-multiplexed controller for the LeNet layer-3 convolution: 2 input maps of 5×5 and 10 kernels of 2×5×5 produce 10 scalar outputs. The block walks the input-map and kernel storage through address ports and drives a single MAC datapath. It emits the 10 results one at a time over a valid/ready stream. It sits between the layer-2 feature-map buffer / kernel ROM and the layer-4 input buffer, and replaces the fully parallel combinational layer-3 datapath.

---
 rtl/conv3_pkg.sv | 15 +
 rtl/conv3_if.sv | 23 ++
 rtl/conv3_mac.sv | 28 ++
 rtl/conv3_sequencer.sv | 98 +++++++++
 tb/tb_conv3_sequencer.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/conv3_pkg.sv
// Shared sizing constants and FSM state type for the layer-3 convolution sequencer.
package conv3_pkg;
  localparam int BITWIDTH = 32;
  localparam int IN_CH    = 2;
  localparam int KSIZE    = 5;
  localparam int OUT_CH   = 10;
  localparam int ELEMS    = IN_CH * KSIZE * KSIZE;
  localparam int FM_AW    = $clog2(ELEMS);
  localparam int KW_AW    = $clog2(OUT_CH * ELEMS);
  localparam int IDX_W    = 4;

  typedef enum logic [2:0] {
    IDLE, FETCH, DRAIN, EMIT, DONE
  } conv3_state_t;
endpackage

// File: rtl/conv3_if.sv
// Memory read ports and result stream between the sequencer (master) and its environment.
interface conv3_if;
  import conv3_pkg::*;

  logic [FM_AW-1:0]    fm_addr;
  logic [BITWIDTH-1:0] fm_data;
  logic [KW_AW-1:0]    kw_addr;
  logic [BITWIDTH-1:0] kw_data;
  logic                out_valid;
  logic                out_ready;
  logic [IDX_W-1:0]    out_idx;
  logic [BITWIDTH-1:0] out_data;

  modport master (
    output fm_addr, kw_addr, out_valid, out_idx, out_data,
    input  fm_data, kw_data, out_ready
  );

  modport slave (
    input  fm_addr, kw_addr, out_valid, out_idx, out_data,
    output fm_data, kw_data, out_ready
  );
endinterface

// File: rtl/conv3_mac.sv
// Signed multiply-accumulate; product truncated to W bits, sum wraps modulo 2^W.
module conv3_mac #(
  parameter int W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] acc
);
  logic signed [W-1:0] acc_q, acc_d, prod;

  always_comb begin
    prod  = W'(a * b);
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = acc_q + prod;
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;
endmodule

// File: rtl/conv3_sequencer.sv
// Time-multiplexed LeNet layer-3 convolution: one MAC walks 50 elements per output channel.
// Optional CONV3_RELU_EN clamps negative results to zero on the output stream only.
module conv3_sequencer
  import conv3_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     start,
  output logic     busy,
  output logic     done,
  conv3_if.master  bus
);
  conv3_state_t               state_q, state_d;
  logic [FM_AW-1:0]           e_q, e_d;
  logic [IDX_W-1:0]           o_q, o_d;
  logic                       en_q;
  logic                       clr;
  logic signed [BITWIDTH-1:0] acc, emit_data;

  // Read data lags the address by one cycle, so accumulation trails FETCH by one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      e_q     <= '0;
      o_q     <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      o_q     <= o_d;
      en_q    <= (state_q == FETCH);
    end
  end

  always_comb begin
    state_d = state_q;
    e_d     = e_q;
    o_d     = o_q;
    clr     = 1'b0;
    case (state_q)
      IDLE:  if (start) begin
               state_d = FETCH;
               o_d     = '0;
             end
      FETCH: if (e_q == FM_AW'(ELEMS - 1)) state_d = DRAIN;
             else                          e_d     = e_q + 1'b1;
      DRAIN: state_d = EMIT;
      EMIT:  if (bus.out_ready) begin
               if (o_q == IDX_W'(OUT_CH - 1)) state_d = DONE;
               else begin
                 o_d     = o_q + 1'b1;
                 state_d = FETCH;
               end
             end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == FETCH && state_q != FETCH) begin
      clr = 1'b1;
      e_d = '0;
    end
  end

  conv3_mac #(.W(BITWIDTH)) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (en_q),
    .a   ($signed(bus.fm_data)),
    .b   ($signed(bus.kw_data)),
    .acc (acc)
  );

`ifdef CONV3_RELU_EN
  assign emit_data = acc[BITWIDTH-1] ? '0 : acc;
`else
  assign emit_data = acc;
`endif

  always_comb begin
    busy          = (state_q != IDLE);
    done          = (state_q == DONE);
    bus.fm_addr   = '0;
    bus.kw_addr   = '0;
    bus.out_valid = 1'b0;
    bus.out_idx   = '0;
    bus.out_data  = '0;
    if (state_q == FETCH) begin
      bus.fm_addr = e_q;
      bus.kw_addr = KW_AW'(o_q) * KW_AW'(ELEMS) + KW_AW'(e_q);
    end
    if (state_q == EMIT) begin
      bus.out_valid = 1'b1;
      bus.out_idx   = o_q;
      bus.out_data  = emit_data;
    end
  end
endmodule

// File: tb/tb_conv3_sequencer.sv
// Directed bench for conv3_sequencer: reset, data patterns, backpressure, sign, abort/restart.
module tb_conv3_sequencer;
  logic clk, rst, start, busy, done;
  conv3_if bus ();

  conv3_sequencer dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  logic [31:0] fm_mem [64];
  logic [31:0] kw_mem [512];
  logic [31:0] exp_data [10];
  int nchk, nerr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus.fm_data <= fm_mem[bus.fm_addr];
    bus.kw_data <= kw_mem[bus.kw_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // mode 0: basic (17), 1: per-output index (o+1), 2: negative ch1 kernel (-19)
  task automatic set_mem(input int mode);
    for (int i = 0; i < 64; i++) fm_mem[i] = 32'd0;
    for (int i = 0; i < 512; i++) kw_mem[i] = 32'd0;
    if (mode == 1) begin
      fm_mem[0] = 32'd1;
      for (int o = 0; o < 10; o++) begin
        for (int i = 0; i < 50; i++) kw_mem[o*50+i] = o + 1;
        exp_data[o] = o + 1;
      end
    end else begin
      fm_mem[0]  = 32'd1;
      fm_mem[25] = 32'd5;
      fm_mem[10] = 32'd10;
      fm_mem[35] = -32'sd2;
      for (int o = 0; o < 10; o++) begin
        for (int i = 0; i < 50; i++)
          kw_mem[o*50+i] = (i < 25) ? 32'd1 : ((mode == 2) ? -32'sd10 : 32'd2);
`ifdef CONV3_RELU_EN
        exp_data[o] = (mode == 2) ? 32'd0 : 32'd17;
`else
        exp_data[o] = (mode == 2) ? 32'hFFFF_FFED : 32'd17;
`endif
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_idx"}, bus.out_idx, 0);
    chk({tag, "_data"}, bus.out_data, 0);
    chk({tag, "_fm"}, bus.fm_addr, 0);
    chk({tag, "_kw"}, bus.kw_addr, 0);
  endtask

  task automatic run_pass(input int stall_idx, input int stall_n, input int exp_done,
                          input int pulse_at);
    int n, stalls, first_v, done_rel;
    logic [31:0] held;
    bit held_v;
    n = 0; stalls = 0; first_v = -1; done_rel = -1; held_v = 0; held = '0;
    @(negedge clk); start = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int r = 1; r < 700; r++) begin
      if (r > 1) @(negedge clk);
      start = (r == pulse_at);
      if (r == 1) begin
        chk("busy_c1", busy, 1);
        chk("fm_c1", bus.fm_addr, 0);
        chk("kw_c1", bus.kw_addr, 0);
      end
      if (r == 3) begin
        chk("fm_c3", bus.fm_addr, 2);
        chk("kw_c3", bus.kw_addr, 2);
      end
      if (r == 55) begin
        chk("fm_c55", bus.fm_addr, 2);
        chk("kw_c55", bus.kw_addr, 52);
      end
      if (bus.out_valid && first_v < 0) first_v = r;
      if (bus.out_valid) begin
        if (held_v) chk("hold", bus.out_data, held);
        if (int'(bus.out_idx) == stall_idx && stalls < stall_n) begin
          bus.out_ready = 1'b0;
          stalls++;
          held = bus.out_data;
          held_v = 1;
        end else begin
          bus.out_ready = 1'b1;
          chk("idx", bus.out_idx, n);
          chk("data", bus.out_data, (n < 10) ? exp_data[n] : 32'hDEAD_BEEF);
          n++;
          held_v = 0;
        end
      end else bus.out_ready = 1'b1;
      if (done) begin
        done_rel = r;
        break;
      end
    end
    chk("n_out", n, 10);
    chk("first_valid", first_v, 52);
    chk("done_cyc", done_rel, exp_done);
    @(negedge clk);
    chk("busy_end", busy, 0);
    chk("done_end", done, 0);
  endtask

  initial begin
    nchk = 0; nerr = 0;
    rst = 1'b1; start = 1'b1; bus.out_ready = 1'b0;
    set_mem(0);
    @(negedge clk); chk_all_zero("rst1");
    @(negedge clk); chk_all_zero("rst2");
    rst = 1'b0; start = 1'b0;
    @(negedge clk); chk_all_zero("idle");

    run_pass(-1, 0, 521, 100);
    set_mem(1);
    run_pass(-1, 0, 521, 0);
    set_mem(0);
    run_pass(3, 7, 528, 0);
    set_mem(2);
    run_pass(-1, 0, 521, 0);

    // Abort mid-pass, then a clean full pass.
    set_mem(0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (199) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk_all_zero("abort");
    @(negedge clk); chk("abort_idle", busy, 0);
    run_pass(-1, 0, 521, 0);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule
